// File: rtl/player_ctrl_pkg.sv
// player_ctrl_pkg
// Shared constants and helpers for the MP3 player front panel. The same
// volume and song limits are used by the display block and the decoder.
//   VOL_MAX / VOL_MIN     : volume saturation limits
//   NUM_SONGS_DEF         : default song count
//   VOL_DEFAULT_DEF       : default volume after reset
//   song_inc / song_dec   : wrapping song index arithmetic
package player_ctrl_pkg;

  localparam logic [3:0] VOL_MAX         = 4'd15;
  localparam logic [3:0] VOL_MIN         = 4'd0;
  localparam int         NUM_SONGS_DEF   = 4;
  localparam int         VOL_DEFAULT_DEF = 8;

  // Index of each button in the per-button press vector.
  typedef enum logic [2:0] {
    BTN_NEXT  = 3'd0,
    BTN_PRE   = 3'd1,
    BTN_UP    = 3'd2,
    BTN_DOWN  = 3'd3,
    BTN_PAUSE = 3'd4
  } btn_id_e;

  function automatic logic [3:0] song_inc(input logic [3:0] idx,
                                          input logic [3:0] last);
    return (idx == last) ? 4'd0 : idx + 4'd1;
  endfunction

  function automatic logic [3:0] song_dec(input logic [3:0] idx,
                                          input logic [3:0] last);
    return (idx == 4'd0) ? last : idx - 4'd1;
  endfunction

endpackage

// File: rtl/player_ctrl_btn_debounce.sv
// btn_debounce
// One push-button conditioner: 2-flop synchroniser, hold-time debounce
// counter, stable register and rising-edge detector.
//   CLK     in  : system clock
//   RST_BTN in  : asynchronous active-high reset
//   btn_raw in  : raw asynchronous bouncing button, 1 = pressed
//   press   out : 1-cycle pulse on each accepted 0->1 transition
module btn_debounce
  import player_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic CLK,
  input  logic RST_BTN,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level, so any return to the old level restarts the hold time.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Release edges are deliberately ignored.
  assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl
// Front-panel control for the MP3 player: debounces the five buttons,
// arbitrates requests and keeps volume, song index and pause state.
//   CLK, RST_BTN        : clock, asynchronous active-high reset
//   btn_next/pre/up/down/pause : raw buttons, 1 = pressed
//   i_finish_song       : decoder level, rising edge = song ended
//   o_next/o_pre/o_vol_plus/o_vol_dec : 1-cycle command pulses
//   o_pause             : 1 = paused
//   vol_level           : volume 0..15
//   song_idx            : song 0..NUM_SONGS-1
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int NUM_SONGS       = NUM_SONGS_DEF,
  parameter int VOL_DEFAULT     = VOL_DEFAULT_DEF
) (
  input  logic       CLK,
  input  logic       RST_BTN,
  input  logic       btn_next,
  input  logic       btn_pre,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_pause,
  input  logic       i_finish_song,
  output logic       o_next,
  output logic       o_pre,
  output logic       o_vol_plus,
  output logic       o_vol_dec,
  output logic       o_pause,
  output logic [3:0] vol_level,
  output logic [3:0] song_idx
);

  localparam logic [3:0] SONG_LAST = 4'(NUM_SONGS - 1);
  localparam logic [3:0] VOL_RST   = 4'(VOL_DEFAULT);

  logic [4:0] btn_raw;
  logic [4:0] press;

  assign btn_raw = {btn_pause, btn_down, btn_up, btn_pre, btn_next};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn (
      .CLK    (CLK),
      .RST_BTN(RST_BTN),
      .btn_raw(btn_raw[g]),
      .press  (press[g])
    );
  end

  // Song-end edge is registered so the update lands one edge after the
  // decoder level is first sampled high.
  logic fin_q;
  logic fin_rise_q, fin_rise_d;

  logic       next_q, next_d;
  logic       pre_q, pre_d;
  logic       plus_q, plus_d;
  logic       dec_q, dec_d;
  logic       pause_q, pause_d;
  logic [3:0] vol_q, vol_d;
  logic [3:0] song_q, song_d;

  logic next_req, prev_req, up_req, down_req;
  logic do_next, do_prev;

  always_comb begin
    fin_rise_d = i_finish_song & ~fin_q;

    // A button next and a song end in the same cycle merge into one request.
    next_req = press[BTN_NEXT] | fin_rise_q;
    prev_req = press[BTN_PRE];
    up_req   = press[BTN_UP];
    down_req = press[BTN_DOWN];

    // Opposing requests in one cycle cancel each other.
    do_next = next_req & ~prev_req;
    do_prev = prev_req & ~next_req;

    next_d  = do_next;
    pre_d   = do_prev;
    plus_d  = 1'b0;
    dec_d   = 1'b0;
    vol_d   = vol_q;
    song_d  = song_q;
    pause_d = pause_q;

    if (do_next) song_d = song_inc(song_q, SONG_LAST);
    if (do_prev) song_d = song_dec(song_q, SONG_LAST);

    // Pulse only when the level really moves; presses at a limit are dropped.
    if (up_req && !down_req && vol_q != VOL_MAX) begin
      vol_d  = vol_q + 4'd1;
      plus_d = 1'b1;
    end else if (down_req && !up_req && vol_q != VOL_MIN) begin
      vol_d = vol_q - 4'd1;
      dec_d = 1'b1;
    end

    // A song change always resumes playback, overriding a pause toggle.
    if (do_next || do_prev) begin
      pause_d = 1'b0;
    end else if (press[BTN_PAUSE]) begin
      pause_d = ~pause_q;
    end
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      fin_q      <= 1'b0;
      fin_rise_q <= 1'b0;
      next_q     <= 1'b0;
      pre_q      <= 1'b0;
      plus_q     <= 1'b0;
      dec_q      <= 1'b0;
      pause_q    <= 1'b0;
      vol_q      <= VOL_RST;
      song_q     <= 4'd0;
    end else begin
      fin_q      <= i_finish_song;
      fin_rise_q <= fin_rise_d;
      next_q     <= next_d;
      pre_q      <= pre_d;
      plus_q     <= plus_d;
      dec_q      <= dec_d;
      pause_q    <= pause_d;
      vol_q      <= vol_d;
      song_q     <= song_d;
    end
  end

  assign o_next     = next_q;
  assign o_pre      = pre_q;
  assign o_vol_plus = plus_q;
  assign o_vol_dec  = dec_q;
  assign o_pause    = pause_q;
  assign vol_level  = vol_q;
  assign song_idx   = song_q;

endmodule

// File: tb/tb_player_ctrl.sv
module tb_player_ctrl;

  logic       CLK = 1'b0;
  logic       RST_BTN;
  logic       btn_next, btn_pre, btn_up, btn_down, btn_pause;
  logic       i_finish_song;
  logic       o_next, o_pre, o_vol_plus, o_vol_dec, o_pause;
  logic [3:0] vol_level, song_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int c_next, c_pre, c_plus, c_dec;
  int cyc, first_next, first_plus, first_dec;

  always #5 CLK = ~CLK;

  player_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .NUM_SONGS      (4),
    .VOL_DEFAULT    (8)
  ) dut (
    .CLK          (CLK),
    .RST_BTN      (RST_BTN),
    .btn_next     (btn_next),
    .btn_pre      (btn_pre),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_pause    (btn_pause),
    .i_finish_song(i_finish_song),
    .o_next       (o_next),
    .o_pre        (o_pre),
    .o_vol_plus   (o_vol_plus),
    .o_vol_dec    (o_vol_dec),
    .o_pause      (o_pause),
    .vol_level    (vol_level),
    .song_idx     (song_idx)
  );

  task automatic clr_counts();
    c_next = 0; c_pre = 0; c_plus = 0; c_dec = 0;
    cyc = 0; first_next = -1; first_plus = -1; first_dec = -1;
  endtask

  // Advance n clock edges, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (o_next)     begin c_next++; if (first_next < 0) first_next = cyc; end
      if (o_pre)      c_pre++;
      if (o_vol_plus) begin c_plus++; if (first_plus < 0) first_plus = cyc; end
      if (o_vol_dec)  begin c_dec++;  if (first_dec  < 0) first_dec  = cyc; end
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btn_pause, btn_down, btn_up, btn_pre, btn_next} = m;
  endtask

  // mask bits: 0 next, 1 pre, 2 up, 3 down, 4 pause
  task automatic press(input logic [4:0] m);
    set_btns(m);
    step(8);
    set_btns(5'b0);
    step(8);
  endtask

  task automatic do_reset();
    RST_BTN = 1'b1;
    step(2);
    RST_BTN = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    RST_BTN = 1'b1;
    step(3);
    RST_BTN = 1'b0;
    clr_counts();
    step(5);
    n_checks++;
    if (vol_level !== 4'd8) begin n_fail++; $display("FAIL reset_vol: got %0d want 8", vol_level); end
    n_checks++;
    if (song_idx !== 4'd0) begin n_fail++; $display("FAIL reset_song: got %0d want 0", song_idx); end
    n_checks++;
    if (o_pause !== 1'b0) begin n_fail++; $display("FAIL reset_pause: got %b want 0", o_pause); end
    n_checks++;
    if ((c_next + c_pre + c_plus + c_dec) !== 0) begin
      n_fail++; $display("FAIL reset_pulses: got %0d want 0", c_next + c_pre + c_plus + c_dec);
    end
  endtask

  task automatic test_clean_press();
    clr_counts();
    btn_up = 1'b1;
    step(10);
    btn_up = 1'b0;
    step(8);
    n_checks++;
    if (c_plus !== 1) begin n_fail++; $display("FAIL press_count: got %0d want 1", c_plus); end
    n_checks++;
    if (first_plus !== 7) begin n_fail++; $display("FAIL press_latency: got edge %0d want 7", first_plus); end
    n_checks++;
    if (vol_level !== 4'd9) begin n_fail++; $display("FAIL press_vol: got %0d want 9", vol_level); end
    // Bounce 1,0,1 then low: never held long enough.
    clr_counts();
    btn_up = 1'b1; step(1);
    btn_up = 1'b0; step(1);
    btn_up = 1'b1; step(1);
    btn_up = 1'b0; step(10);
    n_checks++;
    if (c_plus !== 0) begin n_fail++; $display("FAIL bounce_pulse: got %0d want 0", c_plus); end
    n_checks++;
    if (vol_level !== 4'd9) begin n_fail++; $display("FAIL bounce_vol: got %0d want 9", vol_level); end
  endtask

  task automatic test_volume();
    do_reset();
    clr_counts();
    for (int i = 0; i < 8; i++) press(5'b00100);
    n_checks++;
    if (c_plus !== 7) begin n_fail++; $display("FAIL vol_up_pulses: got %0d want 7", c_plus); end
    n_checks++;
    if (vol_level !== 4'd15) begin n_fail++; $display("FAIL vol_max: got %0d want 15", vol_level); end
    clr_counts();
    for (int i = 0; i < 16; i++) press(5'b01000);
    n_checks++;
    if (c_dec !== 15) begin n_fail++; $display("FAIL vol_dn_pulses: got %0d want 15", c_dec); end
    n_checks++;
    if (vol_level !== 4'd0) begin n_fail++; $display("FAIL vol_min: got %0d want 0", vol_level); end
    n_checks++;
    if (c_plus !== 0) begin n_fail++; $display("FAIL vol_dn_plus: got %0d want 0", c_plus); end
  endtask

  task automatic test_song();
    do_reset();
    clr_counts();
    for (int i = 0; i < 3; i++) press(5'b00001);
    n_checks++;
    if (song_idx !== 4'd3 || c_next !== 3) begin
      n_fail++; $display("FAIL song_to3: got idx %0d pulses %0d want 3 3", song_idx, c_next);
    end
    clr_counts();
    press(5'b00001);
    n_checks++;
    if (song_idx !== 4'd0 || c_next !== 1) begin
      n_fail++; $display("FAIL song_wrap_up: got idx %0d pulses %0d want 0 1", song_idx, c_next);
    end
    clr_counts();
    press(5'b00010);
    n_checks++;
    if (song_idx !== 4'd3 || c_pre !== 1) begin
      n_fail++; $display("FAIL song_wrap_dn: got idx %0d pulses %0d want 3 1", song_idx, c_pre);
    end
    clr_counts();
    press(5'b00011);
    n_checks++;
    if (song_idx !== 4'd3 || c_next !== 0 || c_pre !== 0) begin
      n_fail++; $display("FAIL song_cancel: got idx %0d next %0d pre %0d want 3 0 0", song_idx, c_next, c_pre);
    end
  endtask

  task automatic test_pause_song_end();
    press(5'b10000);
    n_checks++;
    if (o_pause !== 1'b1) begin n_fail++; $display("FAIL pause_set: got %b want 1", o_pause); end
    clr_counts();
    i_finish_song = 1'b1;
    step(1);
    n_checks++;
    if (c_next !== 0) begin n_fail++; $display("FAIL end_early: got %0d pulses want 0", c_next); end
    step(1);
    n_checks++;
    if (first_next !== 2 || c_next !== 1) begin
      n_fail++; $display("FAIL end_pulse: got edge %0d count %0d want 2 1", first_next, c_next);
    end
    n_checks++;
    if (song_idx !== 4'd0) begin n_fail++; $display("FAIL end_song: got %0d want 0", song_idx); end
    n_checks++;
    if (o_pause !== 1'b0) begin n_fail++; $display("FAIL end_unpause: got %b want 0", o_pause); end
    step(3);
    i_finish_song = 1'b0;
    step(3);
    // Button next first sampled at edge 1 acts at edge 7; song end sampled
    // at edge 6 also acts at edge 7.
    clr_counts();
    btn_next = 1'b1;
    step(5);
    i_finish_song = 1'b1;
    step(5);
    btn_next = 1'b0;
    i_finish_song = 1'b0;
    step(8);
    n_checks++;
    if (c_next !== 1 || first_next !== 7) begin
      n_fail++; $display("FAIL coincident_pulse: got count %0d edge %0d want 1 7", c_next, first_next);
    end
    n_checks++;
    if (song_idx !== 4'd1) begin n_fail++; $display("FAIL coincident_song: got %0d want 1", song_idx); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(5'b00100);
    press(5'b10000);
    clr_counts();
    btn_down = 1'b1;
    step(2);
    RST_BTN = 1'b1;
    #1;
    n_checks++;
    if (vol_level !== 4'd8 || o_pause !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got vol %0d pause %b want 8 0", vol_level, o_pause);
    end
    step(1);
    RST_BTN = 1'b0;
    clr_counts();
    step(6);
    n_checks++;
    if (c_dec !== 0) begin n_fail++; $display("FAIL mid_early: got %0d pulses want 0", c_dec); end
    step(1);
    n_checks++;
    if (c_dec !== 1 || first_dec !== 7) begin
      n_fail++; $display("FAIL mid_pulse: got count %0d edge %0d want 1 7", c_dec, first_dec);
    end
    n_checks++;
    if (vol_level !== 4'd7) begin n_fail++; $display("FAIL mid_vol: got %0d want 7", vol_level); end
    btn_down = 1'b0;
    step(8);
  endtask

  initial begin
    RST_BTN = 1'b1;
    set_btns(5'b0);
    i_finish_song = 1'b0;
    clr_counts();
    test_reset();
    test_clean_press();
    test_volume();
    test_song();
    test_pause_song_end();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
